// File: rtl/sobel_window_gen.sv
// Purpose : builds raster-ordered 3x3 pixel windows for a Sobel core from a gray pixel stream.
// Latency : a window is presented one cycle after the pixel that completes it is accepted.
// Backpressure: px_ready_o = !win_valid_o || win_ready_i; a held window stalls the pixel input.
// Ports:
//   clk_i, reset_i            - clock, synchronous active-high reset
//   px_valid_i/px_gray_i      - upstream pixel offer (raster order), px_ready_o accepts
//   win_valid_o/win_o         - 3x3 window offer, slot k=3*r+c at [PX_W*k +: PX_W]
//   win_ready_i               - downstream takes the window
//   win_row_o/win_col_o       - centre pixel coordinates of the offered window
//   frame_done_o              - one-cycle pulse after the last pixel of a frame is accepted
module sobel_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PX_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              px_valid_i,
  input  logic [PX_W-1:0]   px_gray_i,
  output logic              px_ready_o,
  output logic              win_valid_o,
  output logic [9*PX_W-1:0] win_o,
  input  logic              win_ready_i,
  output logic [5:0]        win_row_o,
  output logic [5:0]        win_col_o,
  output logic              frame_done_o
);

  // Line buffers are sized to a power of two so the column counter slices
  // straight into an index; entries at or beyond IMG_W are never touched.
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LB_N = 1 << XW;
  localparam logic [5:0] X_LAST = 6'(IMG_W - 1);
  localparam logic [5:0] Y_LAST = 6'(IMG_H - 1);

  logic [5:0]        x_q, x_d;
  logic [5:0]        y_q, y_d;
  logic              win_valid_q, win_valid_d;
  logic [9*PX_W-1:0] win_q, win_d;
  logic [5:0]        win_row_q, win_row_d;
  logic [5:0]        win_col_q, win_col_d;
  logic              frame_done_q, frame_done_d;
  logic [PX_W-1:0]   lb0_q [LB_N];
  logic [PX_W-1:0]   lb0_d [LB_N];
  logic [PX_W-1:0]   lb1_q [LB_N];
  logic [PX_W-1:0]   lb1_d [LB_N];

  logic          accept;
  logic          produce;
  logic [XW-1:0] x_idx;

  assign px_ready_o   = !win_valid_q || win_ready_i;
  assign accept       = px_valid_i && px_ready_o;
  assign x_idx        = x_q[XW-1:0];
  // Only once two full rows and two columns of the current frame are in
  // does the window hold real pixels; this also hides stale line-buffer data.
  assign produce      = accept && (y_q >= 6'd2) && (x_q >= 6'd2);

  assign win_valid_o  = win_valid_q;
  assign win_o        = win_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign frame_done_o = frame_done_q;

  // Raster counters
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_q == X_LAST) begin
        x_d = 6'd0;
        y_d = (y_q == Y_LAST) ? 6'd0 : y_q + 6'd1;
      end else begin
        x_d = x_q + 6'd1;
      end
    end
  end

  assign frame_done_d = accept && (x_q == X_LAST) && (y_q == Y_LAST);

  // Line buffers: the row above moves up one slot, the new pixel lands in LB1.
  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    if (accept) begin
      lb0_d[x_idx] = lb1_q[x_idx];
      lb1_d[x_idx] = px_gray_i;
    end
  end

  // Window shift register: columns slide left on every accept (even when no
  // window is produced) so the two older columns are ready at column 2.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[PX_W*(3*r)   +: PX_W] = win_q[PX_W*(3*r+1) +: PX_W];
        win_d[PX_W*(3*r+1) +: PX_W] = win_q[PX_W*(3*r+2) +: PX_W];
      end
      win_d[PX_W*2 +: PX_W] = lb0_q[x_idx];
      win_d[PX_W*5 +: PX_W] = lb1_q[x_idx];
      win_d[PX_W*8 +: PX_W] = px_gray_i;
    end
  end

  // Output handshake: a producing accept overrides the handoff so back-to-back
  // windows flow without a bubble; otherwise a taken window drops valid.
  always_comb begin
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (produce) begin
      win_valid_d = 1'b1;
      win_row_d   = y_q - 6'd1;
      win_col_d   = x_q - 6'd1;
    end else if (win_ready_i) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q          <= 6'd0;
      y_q          <= 6'd0;
      win_valid_q  <= 1'b0;
      win_q        <= '0;
      win_row_q    <= 6'd0;
      win_col_q    <= 6'd0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_valid_q  <= win_valid_d;
      win_q        <= win_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line-buffer contents are don't-care after reset; no reset needed.
  always_ff @(posedge clk_i) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
  end

endmodule
